// File: rtl/ucus_kapisi_if.sv
// Gate-side bundle: upstream check-in results and gate commands in, gate status out.
interface ucus_kapisi_if #(
    parameter int BIT = 6
);
    logic           gecerli;
    logic           kalkis;
    logic [8:0]     k_bakiye;
    logic [BIT-1:0] kimlik_no;
    logic           kapi_ac;
    logic           kapi_kapat;

    logic [1:0]     durum;
    logic [3:0]     yolcu_sayisi;
    logic [12:0]    toplam_bakiye;
    logic [7:0]     reddedilen;
    logic [BIT-1:0] son_kimlik;
    logic           dolu;
    logic           ucak_kalkti;

    modport master (
        output gecerli, kalkis, k_bakiye, kimlik_no, kapi_ac, kapi_kapat,
        input  durum, yolcu_sayisi, toplam_bakiye, reddedilen, son_kimlik,
               dolu, ucak_kalkti
    );

    modport slave (
        input  gecerli, kalkis, k_bakiye, kimlik_no, kapi_ac, kapi_kapat,
        output durum, yolcu_sayisi, toplam_bakiye, reddedilen, son_kimlik,
               dolu, ucak_kalkti
    );
endinterface

// File: rtl/ucus_kapisi.sv
// Boarding gate controller: KAPALI -> BINIS -> DOLU (BEKLEME cycles) -> KALKIS -> KAPALI.
module ucus_kapisi #(
    parameter int BIT      = 6,
    parameter int KAPASITE = 4,
    parameter int BEKLEME  = 3
) (
    input  logic          saat,
    input  logic          reset,
    ucus_kapisi_if.slave  bus
);
    typedef enum logic [1:0] {
        KAPALI = 2'b00,
        BINIS  = 2'b01,
        DOLU   = 2'b10,
        KALKIS = 2'b11
    } durum_t;

    localparam logic [3:0] KAPASITE_L = 4'(KAPASITE);
    localparam logic [3:0] BEKLEME_SON = 4'(BEKLEME - 1);

    durum_t         durum_q;
    logic [3:0]     yolcu_q;
    logic [12:0]    toplam_q;
    logic [7:0]     red_q;
    logic [BIT-1:0] son_q;
    logic           dolu_q;
    logic           kalkti_q;
    logic [3:0]     bekle_q;

    logic           binis_kabul;
    logic           binis_red;
    logic [3:0]     yolcu_sonra;

    function automatic logic [7:0] doyumlu_artir(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign binis_kabul = bus.gecerli & bus.kalkis;
    assign binis_red   = bus.gecerli & ~bus.kalkis;
    // Close decision must see the count including a record arriving this same cycle.
    assign yolcu_sonra = yolcu_q + {3'b000, binis_kabul};

    always_ff @(posedge saat) begin
        if (reset) begin
            durum_q  <= KAPALI;
            yolcu_q  <= '0;
            toplam_q <= '0;
            red_q    <= '0;
            son_q    <= '0;
            dolu_q   <= 1'b0;
            kalkti_q <= 1'b0;
            bekle_q  <= '0;
        end else begin
            case (durum_q)
                KAPALI: begin
                    if (bus.kapi_ac) begin
                        durum_q  <= BINIS;
                        yolcu_q  <= '0;
                        toplam_q <= '0;
                        son_q    <= '0;
                    end
                end
                BINIS: begin
                    if (binis_kabul) begin
                        yolcu_q  <= yolcu_sonra;
                        toplam_q <= toplam_q + 13'(bus.k_bakiye);
                        son_q    <= bus.kimlik_no;
                    end
                    if (binis_red) begin
                        red_q <= doyumlu_artir(red_q);
                    end
                    if ((yolcu_sonra == KAPASITE_L) ||
                        (bus.kapi_kapat && (yolcu_sonra != 4'd0))) begin
                        durum_q <= DOLU;
                        dolu_q  <= 1'b1;
                        bekle_q <= '0;
                    end else if (bus.kapi_kapat) begin
                        durum_q <= KAPALI;
                    end
                end
                DOLU: begin
                    if (bekle_q == BEKLEME_SON) begin
                        durum_q  <= KALKIS;
                        dolu_q   <= 1'b0;
                        kalkti_q <= 1'b1;
                    end else begin
                        bekle_q <= bekle_q + 4'd1;
                    end
                end
                KALKIS: begin
                    durum_q  <= KAPALI;
                    kalkti_q <= 1'b0;
                end
                default: begin
                    durum_q <= KAPALI;
                end
            endcase
        end
    end

    assign bus.durum         = durum_q;
    assign bus.yolcu_sayisi  = yolcu_q;
    assign bus.toplam_bakiye = toplam_q;
    assign bus.reddedilen    = red_q;
    assign bus.son_kimlik    = son_q;
    assign bus.dolu          = dolu_q;
    assign bus.ucak_kalkti   = kalkti_q;
endmodule

// File: tb/tb_ucus_kapisi.sv
// Directed bench for ucus_kapisi with a behavioural gate model and per-cycle comparison.
module tb_ucus_kapisi;
    localparam int BIT = 6;
    localparam int KAP = 4;
    localparam int BEK = 3;

    logic saat = 1'b0;
    logic reset;

    ucus_kapisi_if #(.BIT(BIT)) bus();

    ucus_kapisi #(.BIT(BIT), .KAPASITE(KAP), .BEKLEME(BEK)) dut (
        .saat  (saat),
        .reset (reset),
        .bus   (bus)
    );

    always #5 saat = ~saat;

    int n_chk = 0;
    int n_pass = 0;
    int kalkti_sayac = 0;

    // Model: phase 0 closed, 1 boarding, 2 full, 3 departing; kalan = full cycles left.
    int m_faz = 0, m_yolcu = 0, m_toplam = 0, m_red = 0, m_son = 0, m_kalan = 0;

    task automatic chk(input string ad, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", ad, act, exp);
    endtask

    task automatic model_step(input bit g, input bit k, input int b, input int id,
                              input bit ac, input bit kap, input bit rst);
        if (rst) begin
            m_faz = 0; m_yolcu = 0; m_toplam = 0; m_red = 0; m_son = 0; m_kalan = 0;
        end else if (m_faz == 0) begin
            if (ac) begin
                m_faz = 1; m_yolcu = 0; m_toplam = 0; m_son = 0;
            end
        end else if (m_faz == 1) begin
            if (g && k) begin
                m_yolcu++; m_toplam += b; m_son = id;
            end
            if (g && !k && m_red < 255) m_red++;
            if (m_yolcu == KAP || (kap && m_yolcu > 0)) begin
                m_faz = 2; m_kalan = BEK;
            end else if (kap) begin
                m_faz = 0;
            end
        end else if (m_faz == 2) begin
            m_kalan--;
            if (m_kalan == 0) m_faz = 3;
        end else begin
            m_faz = 0;
        end
    endtask

    always @(negedge saat) begin
        chk("durum", int'(bus.durum), m_faz);
        chk("yolcu_sayisi", int'(bus.yolcu_sayisi), m_yolcu);
        chk("toplam_bakiye", int'(bus.toplam_bakiye), m_toplam);
        chk("reddedilen", int'(bus.reddedilen), m_red);
        chk("son_kimlik", int'(bus.son_kimlik), m_son);
        chk("dolu", int'(bus.dolu), (m_faz == 2) ? 1 : 0);
        chk("ucak_kalkti", int'(bus.ucak_kalkti), (m_faz == 3) ? 1 : 0);
        if (bus.ucak_kalkti) kalkti_sayac++;
    end

    task automatic cyc(input bit g, input bit k, input int b, input int id,
                       input bit ac, input bit kap, input bit rst);
        reset          = rst;
        bus.gecerli    = g;
        bus.kalkis     = k;
        bus.k_bakiye   = 9'(b);
        bus.kimlik_no  = BIT'(id);
        bus.kapi_ac    = ac;
        bus.kapi_kapat = kap;
        @(posedge saat);
        model_step(g, k, b, id, ac, kap, rst);
        @(negedge saat);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_sifir(input string ad);
        chk({ad, "_durum"}, int'(bus.durum), 0);
        chk({ad, "_yolcu"}, int'(bus.yolcu_sayisi), 0);
        chk({ad, "_toplam"}, int'(bus.toplam_bakiye), 0);
        chk({ad, "_red"}, int'(bus.reddedilen), 0);
        chk({ad, "_son"}, int'(bus.son_kimlik), 0);
        chk({ad, "_dolu"}, int'(bus.dolu), 0);
        chk({ad, "_kalkti"}, int'(bus.ucak_kalkti), 0);
    endtask

    initial begin
        // Reset held for two cycles
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk_sifir("reset");

        // Full flight
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("ff_binis", int'(bus.durum), 1);
        cyc(1, 1, 494, 1, 0, 0, 0);
        cyc(1, 1, 94, 2, 0, 0, 0);
        cyc(1, 1, 57, 3, 0, 0, 0);
        cyc(1, 1, 100, 6'b111011, 0, 0, 0);
        chk("ff_yolcu", int'(bus.yolcu_sayisi), 4);
        chk("ff_toplam", int'(bus.toplam_bakiye), 745);
        chk("ff_son", int'(bus.son_kimlik), 59);
        chk("ff_durum", int'(bus.durum), 2);
        chk("ff_dolu", int'(bus.dolu), 1);
        chk("ff_model_toplam", m_toplam, 745);
        cyc(1, 1, 5, 7, 1, 1, 0);
        chk("ff_dolu_yok_say", int'(bus.yolcu_sayisi), 4);
        idle(1);
        chk("ff_dolu3", int'(bus.durum), 2);
        idle(1);
        chk("ff_kalkis", int'(bus.durum), 3);
        chk("ff_kalkti", int'(bus.ucak_kalkti), 1);
        cyc(1, 1, 9, 9, 1, 0, 0);
        chk("ff_kapali", int'(bus.durum), 0);
        chk("ff_kalkti_bitti", int'(bus.ucak_kalkti), 0);
        chk("ff_tutuldu", int'(bus.toplam_bakiye), 745);

        // Record and close in the same cycle
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("ac_temiz_toplam", int'(bus.toplam_bakiye), 0);
        chk("ac_temiz_son", int'(bus.son_kimlik), 0);
        cyc(1, 1, 141, 10, 0, 0, 0);
        cyc(1, 1, 78, 11, 1, 0, 0);
        chk("es_ara_toplam", int'(bus.toplam_bakiye), 219);
        cyc(1, 1, 96, 12, 0, 1, 0);
        chk("es_yolcu", int'(bus.yolcu_sayisi), 3);
        chk("es_toplam", int'(bus.toplam_bakiye), 315);
        chk("es_durum", int'(bus.durum), 2);
        idle(4);
        #1;
        chk("kalkti_sayisi_2", kalkti_sayac, 2);

        // Rejections, empty close, records while closed
        cyc(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 50, 20 + i, 0, 0, 0);
        chk("red_3", int'(bus.reddedilen), 3);
        chk("red_yolcu", int'(bus.yolcu_sayisi), 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("bos_kapat", int'(bus.durum), 0);
        cyc(1, 0, 5, 1, 0, 1, 0);
        cyc(1, 1, 5, 2, 0, 0, 0);
        chk("kapali_red", int'(bus.reddedilen), 3);
        chk("kapali_yolcu", int'(bus.yolcu_sayisi), 0);
        #1;
        chk("bos_kalkti_yok", kalkti_sayac, 2);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("ac_red_kalir", int'(bus.reddedilen), 3);

        // Saturation, then reset mid-boarding
        for (int i = 0; i < 260; i++) cyc(1, 0, 1, 1, 0, 0, 0);
        chk("red_doyum", int'(bus.reddedilen), 255);
        cyc(1, 1, 33, 44, 0, 0, 0);
        chk("binis_yolcu", int'(bus.yolcu_sayisi), 1);
        cyc(1, 1, 33, 45, 0, 0, 1);
        chk_sifir("binis_reset");

        // Reset in the second full cycle
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, 1, 200, 5, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("dolu_gir", int'(bus.durum), 2);
        idle(1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk_sifir("dolu_reset");
        idle(5);
        #1;
        chk("reset_kalkti_yok", kalkti_sayac, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ucus_kapisi.md
UCUS_KAPISI -- requirements
Module: ucus_kapisi

Interface
REQ-001 The block SHALL have parameter BIT, default 6, giving the passenger ID width.
REQ-002 The block SHALL have parameter KAPASITE, default 4, giving seat count; legal range 1..15.
REQ-003 The block SHALL have parameter BEKLEME, default 3, giving the number of DOLU cycles before departure; legal range 1..15.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 saat  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 gecerli  input  1  upstream check-in pipeline result valid this cycle.
REQ-008 kalkis  input  1  upstream verdict; 1 = cleared to board, 0 = rejected.
REQ-009 k_bakiye  input  9  upstream remaining balance for this passenger.
REQ-010 kimlik_no  input  BIT  passenger ID accompanying the result.
REQ-011 kapi_ac  input  1  gate-open command.
REQ-012 kapi_kapat  input  1  early gate-close command.
REQ-013 durum  output  2  state: 00 KAPALI, 01 BINIS, 10 DOLU, 11 KALKIS.
REQ-014 yolcu_sayisi  output  4  passengers boarded on the current flight.
REQ-015 toplam_bakiye  output  13  sum of k_bakiye over boarded passengers.
REQ-016 reddedilen  output  8  cumulative count of rejected results.
REQ-017 son_kimlik  output  BIT  ID of the last boarded passenger.
REQ-018 dolu  output  1  high exactly while durum = DOLU.
REQ-019 ucak_kalkti  output  1  departure pulse, high exactly while durum = KALKIS.

Function
REQ-020 All outputs SHALL be registered or decoded only from registered state; there is no combinational input-to-output path.
REQ-021 KAPALI: kapi_ac = 1 SHALL go to BINIS on the next edge and, on that same edge, clear yolcu_sayisi, toplam_bakiye and son_kimlik.
REQ-022 In KAPALI, gecerli and kapi_kapat SHALL be ignored.
REQ-023 In BINIS, gecerli=1 with kalkis=1 SHALL board the passenger:
  - yolcu_sayisi+1;
  - toplam_bakiye += zero-extended k_bakiye;
  - son_kimlik <= kimlik_no.
REQ-024 In BINIS, gecerli=1 with kalkis=0 SHALL increment reddedilen, saturating at 255; the passenger is not boarded.
REQ-025 If a boarding makes yolcu_sayisi equal KAPASITE, the state SHALL become DOLU on that same edge.
REQ-026 In BINIS, kapi_kapat = 1 SHALL end boarding:
  - go to DOLU if the post-update yolcu_sayisi > 0;
  - otherwise go to KAPALI with no departure.
REQ-027 If gecerli and kapi_kapat are asserted in the same cycle, the record SHALL be processed first; the close decision uses the updated count.
REQ-028 In DOLU, gecerli SHALL be ignored (no count changes), as SHALL kapi_ac and kapi_kapat.
REQ-029 The state SHALL stay in DOLU for exactly BEKLEME cycles, then go to KALKIS.
REQ-030 KALKIS SHALL last one cycle, then go to KAPALI; inputs are ignored during KALKIS.
REQ-031 In KALKIS and KAPALI, yolcu_sayisi, toplam_bakiye and son_kimlik SHALL hold their values until the next kapi_ac.
REQ-032 kapi_ac asserted outside KAPALI SHALL have no effect.
REQ-033 reddedilen SHALL be cleared only by reset, never by kapi_ac.

Reset
REQ-034 When reset = 1 at an edge, the following SHALL become 0 on that edge:
  - durum = KAPALI;
  - yolcu_sayisi, toplam_bakiye, reddedilen, son_kimlik;
  - dolu, ucak_kalkti;
  - the internal wait counter.
REQ-035 Reset SHALL override all other inputs in every state, including mid-DOLU and mid-BINIS.
REQ-036 Reset SHALL NOT produce an ucak_kalkti pulse.

Verification (KAPASITE=4, BEKLEME=3, BIT=6)
REQ-037 Reset asserted for 2 cycles -> all outputs 0, durum=00.
REQ-038 Full-flight scenario:
  - kapi_ac for 1 cycle;
  - then 4 consecutive gecerli/kalkis=1 records with k_bakiye 494, 94, 57, 100 and last ID 6'b111011.
  Required response:
  - after the 4th edge: yolcu_sayisi=4, toplam_bakiye=745, son_kimlik=6'b111011, durum=10, dolu=1;
  - 3 cycles later: durum=11 and ucak_kalkti=1 for one cycle;
  - then durum=00 with totals held.
REQ-039 In BINIS, 3 records with kalkis=0 -> reddedilen=3, yolcu_sayisi=0; then gecerli records in KAPALI -> no counter change.
REQ-040 Simultaneous record and close:
  - boarded 141 and 78 (toplam_bakiye=219);
  - then gecerli/kalkis=1/k_bakiye=96 together with kapi_kapat.
  Required response: yolcu_sayisi=3, toplam_bakiye=315, durum=10.
REQ-041 kapi_kapat in BINIS with 0 passengers -> durum=00 next edge, no ucak_kalkti; a subsequent kapi_ac clears totals but keeps reddedilen.
REQ-042 Reset in the 2nd DOLU cycle -> all outputs 0 on the next edge; ucak_kalkti never asserts.
